// File: rtl/keypad_entry_display.sv
// rtl/keypad_entry_display.sv - 3x4 keypad scanner with BCD entry buffer and multiplexed FND display
module keypad_entry_display #(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 20,
    parameter int REFRESH_DIV  = 10000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            row,
    output logic [2:0]            col,
    output logic                  key_valid,
    output logic [3:0]            key_code,
    output logic [4*DIGITS-1:0]   value,
    output logic [3:0]            digit_count,
    output logic                  full,
    output logic                  fnd_en,
    output logic [DIGITS-1:0]     fnd_sel,
    output logic [7:0]            fnd_data
);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD, RELEASE} state_t;

    localparam logic [DIGITS-1:0] SEL_ONE = DIGITS'(1);

    state_t      state, state_next;
    logic [31:0] scan_cnt;
    logic [31:0] deb_cnt;
    logic [3:0]  cand_row;
    logic        accept;
    logic        row_onehot;
    logic        scan_last;
    logic        deb_last;

    logic [31:0] ref_cnt;
    logic [2:0]  idx;
    logic [2:0]  idx_next;
    logic [3:0]  disp_digit;

    // Map a frozen column and a one-hot row onto the key code
    function automatic logic [3:0] key_lookup(input logic [2:0] c, input logic [3:0] r);
        logic [3:0] k;
        k = 4'd0;
        case (r)
            4'b0001: k = c[0] ? 4'd1 : (c[1] ? 4'd2 : 4'd3);
            4'b0010: k = c[0] ? 4'd4 : (c[1] ? 4'd5 : 4'd6);
            4'b0100: k = c[0] ? 4'd7 : (c[1] ? 4'd8 : 4'd9);
            4'b1000: k = c[0] ? 4'hA : (c[1] ? 4'd0 : 4'hB);
            default: k = 4'd0;
        endcase
        return k;
    endfunction

    // BCD digit to active-high segments {dp,g,f,e,d,c,b,a}
    function automatic logic [7:0] seg_lookup(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'h3f;
            4'd1:    s = 8'h06;
            4'd2:    s = 8'h5b;
            4'd3:    s = 8'h4f;
            4'd4:    s = 8'h66;
            4'd5:    s = 8'h6d;
            4'd6:    s = 8'h7d;
            4'd7:    s = 8'h07;
            4'd8:    s = 8'h7f;
            4'd9:    s = 8'h6f;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

    assign row_onehot = (row != 4'd0) && ((row & (row - 4'd1)) == 4'd0);
    assign scan_last  = (scan_cnt == 32'(SCAN_DIV - 1));
    assign deb_last   = (deb_cnt == 32'(DEBOUNCE_CNT - 1));
    assign full       = (digit_count == 4'(DIGITS));

    // Scanner state register
    always_ff @(posedge clk) begin
        if (!reset) state <= SCAN;
        else        state <= state_next;
    end

    // Scanner next-state; deb_cnt is shared by press and release debouncing
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            SCAN:     if (scan_last && row_onehot) state_next = DEBOUNCE;
            DEBOUNCE: begin
                if (row != cand_row) begin
                    state_next = SCAN;
                end else if (deb_last) begin
                    state_next = HOLD;
                    accept     = 1'b1;
                end
            end
            HOLD:     if (row == 4'd0) state_next = RELEASE;
            RELEASE: begin
                if (row != 4'd0)   state_next = HOLD;
                else if (deb_last) state_next = SCAN;
            end
            default:  state_next = SCAN;
        endcase
    end

    // Column rotation, candidate capture and debounce counting
    always_ff @(posedge clk) begin
        if (!reset) begin
            scan_cnt <= '0;
            deb_cnt  <= '0;
            col      <= 3'b001;
            cand_row <= 4'd0;
        end else begin
            case (state)
                SCAN: begin
                    deb_cnt <= '0;
                    if (scan_last) begin
                        scan_cnt <= '0;
                        if (row_onehot) cand_row <= row;
                        else            col      <= {col[1:0], col[2]};
                    end else begin
                        scan_cnt <= scan_cnt + 32'd1;
                    end
                end
                DEBOUNCE: deb_cnt <= (state_next == DEBOUNCE) ? deb_cnt + 32'd1 : '0;
                RELEASE:  deb_cnt <= (state_next == RELEASE)  ? deb_cnt + 32'd1 : '0;
                default:  deb_cnt <= '0;
            endcase
        end
    end

    // Accepted key pulse and last key code
    always_ff @(posedge clk) begin
        if (!reset) begin
            key_valid <= 1'b0;
            key_code  <= 4'd0;
        end else begin
            key_valid <= accept;
            if (accept) key_code <= key_lookup(col, cand_row);
        end
    end

    // Entry buffer, updated the clock after each key pulse
    always_ff @(posedge clk) begin
        if (!reset) begin
            value       <= '0;
            digit_count <= 4'd0;
        end else if (key_valid) begin
            if (key_code <= 4'd9) begin
                if (digit_count < 4'(DIGITS)) begin
                    value       <= {value[4*DIGITS-5:0], key_code};
                    digit_count <= digit_count + 4'd1;
                end
            end else if (key_code == 4'hA) begin
                value       <= '0;
                digit_count <= 4'd0;
            end else if (digit_count != 4'd0) begin
                value       <= {4'h0, value[4*DIGITS-1:4]};
                digit_count <= digit_count - 4'd1;
            end
        end
    end

    // Next display index and the buffer digit it selects
    always_comb begin
        idx_next   = (idx == 3'(DIGITS - 1)) ? 3'd0 : idx + 3'd1;
        disp_digit = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_next == 3'(i)) disp_digit = value[4*i +: 4];
        end
    end

    // Display multiplexing; select and segments move together on each step
    always_ff @(posedge clk) begin
        if (!reset) begin
            ref_cnt  <= '0;
            idx      <= 3'd0;
            fnd_sel  <= SEL_ONE;
            fnd_data <= 8'h00;
            fnd_en   <= 1'b0;
        end else begin
            fnd_en <= 1'b1;
            if (ref_cnt == 32'(REFRESH_DIV - 1)) begin
                ref_cnt  <= '0;
                idx      <= idx_next;
                fnd_sel  <= SEL_ONE << idx_next;
                fnd_data <= ({1'b0, idx_next} < digit_count) ? seg_lookup(disp_digit) : 8'h00;
            end else begin
                ref_cnt <= ref_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_keypad_entry_display.sv
// tb/tb_keypad_entry_display.sv - directed self-checking bench for keypad_entry_display
module tb_keypad_entry_display;

    localparam int DIGITS = 4;

    logic                clk;
    logic                reset;
    logic [3:0]          row;
    logic [2:0]          col;
    logic                key_valid;
    logic [3:0]          key_code;
    logic [4*DIGITS-1:0] value;
    logic [3:0]          digit_count;
    logic                full;
    logic                fnd_en;
    logic [DIGITS-1:0]   fnd_sel;
    logic [7:0]          fnd_data;

    logic       key_down;
    logic [3:0] key_row;
    logic [2:0] key_col;
    logic       force_en;
    logic [3:0] row_force;

    int n_checks;
    int n_errors;
    int kv_count;
    int kv_base;

    keypad_entry_display #(
        .DIGITS(DIGITS), .SCAN_DIV(4), .DEBOUNCE_CNT(3), .REFRESH_DIV(2)
    ) dut (
        .clk(clk), .reset(reset), .row(row), .col(col),
        .key_valid(key_valid), .key_code(key_code), .value(value),
        .digit_count(digit_count), .full(full), .fnd_en(fnd_en),
        .fnd_sel(fnd_sel), .fnd_data(fnd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad model: a closed key connects its row only while its column is driven
    assign row = force_en ? row_force : ((key_down && (col == key_col)) ? key_row : 4'd0);

    always @(negedge clk) if (key_valid === 1'b1) kv_count++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic press_key(input logic [3:0] k, input int hold_clks);
        int r;
        int c;
        if (k == 4'hA)      begin r = 3; c = 0; end
        else if (k == 4'd0) begin r = 3; c = 1; end
        else if (k == 4'hB) begin r = 3; c = 2; end
        else                begin r = (int'(k) - 1) / 3; c = (int'(k) - 1) % 3; end
        key_row  = 4'b0001 << r;
        key_col  = 3'b001 << c;
        key_down = 1'b1;
        repeat (hold_clks) @(negedge clk);
        key_down = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int k;
        n_checks = 0; n_errors = 0; kv_count = 0;
        key_down = 1'b0; key_row = 4'd0; key_col = 3'b001;
        force_en = 1'b0; row_force = 4'd0;
        reset = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_col", col, 3'b001);
        check("rst_key_valid", key_valid, 0);
        check("rst_key_code", key_code, 0);
        check("rst_value", value, 0);
        check("rst_count", digit_count, 0);
        check("rst_full", full, 0);
        check("rst_fnd_sel", fnd_sel, 1);
        check("rst_fnd_data", fnd_data, 8'h00);
        check("rst_fnd_en", fnd_en, 0);
        reset = 1'b1;
        @(negedge clk);
        check("fnd_en_run", fnd_en, 1);

        // Single press of '5'
        kv_base = kv_count;
        press_key(4'd5, 20);
        check("k5_pulses", kv_count - kv_base, 1);
        check("k5_code", key_code, 5);
        check("k5_value", value, 16'h0005);
        check("k5_count", digit_count, 1);

        // Fill the buffer, then overflow
        do_reset();
        press_key(4'd1, 24);
        press_key(4'd2, 24);
        press_key(4'd3, 24);
        press_key(4'd4, 24);
        check("fill_value", value, 16'h1234);
        check("fill_count", digit_count, 4);
        check("fill_full", full, 1);
        kv_base = kv_count;
        press_key(4'd5, 24);
        check("ovf_pulses", kv_count - kv_base, 1);
        check("ovf_code", key_code, 5);
        check("ovf_value", value, 16'h1234);
        check("ovf_count", digit_count, 4);

        // Backspace, clear, backspace on empty
        press_key(4'hB, 24);
        check("bs_value", value, 16'h0123);
        check("bs_count", digit_count, 3);
        check("bs_full", full, 0);
        press_key(4'hA, 24);
        check("clr_value", value, 0);
        check("clr_count", digit_count, 0);
        kv_base = kv_count;
        press_key(4'hB, 24);
        check("bs0_pulses", kv_count - kv_base, 1);
        check("bs0_code", key_code, 4'hB);
        check("bs0_value", value, 0);
        check("bs0_count", digit_count, 0);

        // Two-clock row glitches landing on every scan phase
        kv_base = kv_count;
        for (int g = 0; g < 4; g++) begin
            force_en = 1'b1; row_force = 4'b0001;
            repeat (2) @(negedge clk);
            row_force = 4'd0;
            repeat (5) @(negedge clk);
        end
        force_en = 1'b0;
        repeat (4) @(negedge clk);
        check("glitch_pulses", kv_count - kv_base, 0);
        check("glitch_value", value, 0);

        // Display of 0042; a working press here also shows the scanner returned to SCAN
        press_key(4'd4, 24);
        press_key(4'd2, 24);
        check("disp_value", value, 16'h0042);
        check("disp_count", digit_count, 2);
        k = 0;
        while (fnd_sel !== 4'd8 && k < 20) begin @(negedge clk); k++; end
        check("sel_sync8", fnd_sel, 4'd8);
        k = 0;
        while (fnd_sel !== 4'd1 && k < 20) begin @(negedge clk); k++; end
        check("sel0", fnd_sel, 4'd1);
        check("data0", fnd_data, 8'h5b);
        @(negedge clk);
        check("sel0_dwell", fnd_sel, 4'd1);
        @(negedge clk);
        check("sel1", fnd_sel, 4'd2);
        check("data1", fnd_data, 8'h66);
        repeat (2) @(negedge clk);
        check("sel2", fnd_sel, 4'd4);
        check("data2", fnd_data, 8'h00);
        repeat (2) @(negedge clk);
        check("sel3", fnd_sel, 4'd8);
        check("data3", fnd_data, 8'h00);
        repeat (2) @(negedge clk);
        check("sel_wrap", fnd_sel, 4'd1);
        check("data_wrap", fnd_data, 8'h5b);

        // Reset during debounce with key '1' still held
        reset = 1'b0;
        repeat (2) @(negedge clk);
        key_row = 4'b0001; key_col = 3'b001; key_down = 1'b1;
        kv_base = kv_count;
        reset = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_kv_none", kv_count - kv_base, 0);
        check("mid_key_valid", key_valid, 0);
        check("mid_key_code", key_code, 0);
        check("mid_col", col, 3'b001);
        check("mid_value", value, 0);
        check("mid_count", digit_count, 0);
        check("mid_fnd_sel", fnd_sel, 1);
        check("mid_fnd_data", fnd_data, 8'h00);
        check("mid_fnd_en", fnd_en, 0);
        kv_base = kv_count;
        reset = 1'b1;
        repeat (6) @(negedge clk);
        check("redeb_early", kv_count - kv_base, 0);
        repeat (10) @(negedge clk);
        check("redeb_pulses", kv_count - kv_base, 1);
        check("redeb_code", key_code, 1);
        key_down = 1'b0;
        repeat (10) @(negedge clk);
        check("redeb_value", value, 16'h0001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
